// File: rtl/key_slice_assembler.sv
// Collects NUM_SLICES slice beats, MSB slice first, into one wide key and holds
// it until downstream takes it. Framing errors drop the frame and pulse frame_err.
module key_slice_assembler #(
  parameter int SLICE_W    = 64,
  parameter int NUM_SLICES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SLICE_W-1:0]            s_data,
  input  logic                          s_last,
  input  logic                          s_abort,
  output logic [SLICE_W*NUM_SLICES-1:0] key_out,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          frame_err,
  output logic [$clog2(NUM_SLICES)-1:0] slice_cnt
);

  localparam int KEY_W = SLICE_W * NUM_SLICES;
  localparam int CNT_W = $clog2(NUM_SLICES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SLICES - 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]       state;
  logic [KEY_W-1:0] asm_buf;
  logic [KEY_W-1:0] merged;
  logic             accept;
  logic             at_last;

  assign s_ready   = (state == COLLECT);
  assign key_valid = (state == HOLD);
  assign accept    = s_valid && s_ready && !s_abort;
  assign at_last   = (slice_cnt == LAST_IDX);

  // Buffer with the incoming beat dropped into its slot; used for both the
  // running store and the completed-key copy so the final slice is included.
  always_comb begin
    merged = asm_buf;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      if (slice_cnt == CNT_W'(i)) begin
        merged[KEY_W-1-SLICE_W*i -: SLICE_W] = s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      asm_buf   <= '0;
      key_out   <= '0;
      slice_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (s_abort) begin
            asm_buf   <= '0;
            slice_cnt <= '0;
          end else if (accept) begin
            if (s_last && at_last) begin
              key_out   <= merged;
              asm_buf   <= '0;
              slice_cnt <= '0;
              state     <= HOLD;
            end else if (s_last != at_last) begin
              asm_buf   <= '0;
              slice_cnt <= '0;
              frame_err <= 1'b1;
            end else begin
              asm_buf   <= merged;
              slice_cnt <= slice_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (key_ready) begin
            state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/key_slice_assembler.md
KEY_SLICE_ASSEMBLER -- requirements
Module: key_slice_assembler

Interface
REQ-001 SHALL have parameter SLICE_W, default 64: bit width of one key slice.
REQ-002 SHALL have parameter NUM_SLICES, default 8: number of slices per key. Key width is SLICE_W*NUM_SLICES = 512.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port s_valid, input, 1: slice beat valid.
REQ-006 SHALL have port s_ready, output, 1: assembler can accept a slice beat.
REQ-007 SHALL have port s_data, input, 64: slice payload.
REQ-008 SHALL have port s_last, input, 1: marks the final slice (index 7) of a key.
REQ-009 SHALL have port s_abort, input, 1: discard the partial key being assembled.
REQ-010 SHALL have port key_out, output, 512: assembled key.
REQ-011 SHALL have port key_valid, output, 1: key_out holds a complete key.
REQ-012 SHALL have port key_ready, input, 1: downstream accepts key_out.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on a framing error.
REQ-014 SHALL have port slice_cnt, output, 3: number of slices accepted in the current frame.

Function
REQ-015 SHALL implement FSM states COLLECT and HOLD; s_ready = 1 only in COLLECT; key_valid = 1 only in HOLD.
REQ-016 SHALL treat a beat as accepted when s_valid && s_ready at a rising edge.
REQ-017 SHALL place accepted slice index i (0..7, arrival order) into bits [511-64*i -: 64] of the assembly buffer, so slice 0 occupies key_out[511:448].
REQ-018 SHALL increment slice_cnt on each accepted non-final beat.
REQ-019 SHALL, on an accepted beat with s_last=1 and slice_cnt=7, copy the completed buffer to key_out, zero the buffer and slice_cnt, and enter HOLD. key_valid is asserted the cycle after the 8th beat (latency 1).
REQ-020 SHALL hold key_out and key_valid stable in HOLD until key_valid && key_ready; on that edge it SHALL return to COLLECT, so s_ready rises the following cycle. There is no same-cycle bypass.
REQ-021 SHALL keep key_out unchanged after handoff until the next completed key overwrites it; partial frames SHALL never appear on key_out.
REQ-022 SHALL treat an accepted beat with s_last=1 and slice_cnt!=7 as a framing error: drop the frame, zero the buffer and slice_cnt, stay in COLLECT, and pulse frame_err for 1 cycle.
REQ-023 SHALL treat an accepted beat with s_last=0 and slice_cnt=7 as a framing error, with the same handling as REQ-022.
REQ-024 SHALL, when s_abort=1 in COLLECT, zero the buffer and slice_cnt and ignore any same-cycle beat (abort wins). No frame_err is raised.
REQ-025 SHALL ignore s_abort in HOLD.
REQ-026 SHALL ignore s_data, s_last and s_valid whenever s_ready=0.

Reset
REQ-027 SHALL, while rst_n=0 at a rising edge, set state=COLLECT, s_ready=1 after reset, key_out=0, key_valid=0, frame_err=0, slice_cnt=0, buffer=0.
REQ-028 SHALL let reset override all other inputs, including mid-frame and in HOLD, discarding any partial or held key.

Verification
REQ-029 SHALL cover this scenario: 8 back-to-back beats with s_data=64'h0000_0000_0000_000i (i=0..7) and s_last on beat 7 -> key_valid=1 the next cycle; key_out[511:448]=0 and key_out[63:0]=7; s_ready=0.
REQ-030 SHALL cover this scenario: key_ready held low for 5 cycles in HOLD while s_valid=1 -> key_out is stable and no beats are accepted; key_ready=1 -> key_valid=0 and s_ready=1 on the next cycle.
REQ-031 SHALL cover this scenario: s_last on beat 3 -> frame_err pulses once and slice_cnt=0; a following correct 8-beat frame assembles cleanly with no residue from the bad frame.
REQ-032 SHALL cover this scenario: 5 beats, then s_abort together with s_valid=1 -> slice_cnt=0, no frame_err, key_out unchanged from its previous value.
REQ-033 SHALL cover this scenario: rst_n=0 for 1 cycle in HOLD with key_out=all-ones -> key_out=0, key_valid=0, s_ready=1.
REQ-034 SHALL cover this scenario: random s_valid/key_ready gaps over 100 frames -> every key_out matches a scoreboard concatenation of slice 0 (MSB) through slice 7 (LSB).
